serial_add_seq: RTL and testbench

Bit-serial adder sequencer that reuses one full-adder cell (propagate/generate/sum) over WIDTH cycles to add two WIDTH-bit operands, LSB first.
- Owns the carry flop, operand shift registers, bit counter and start/busy/done handshake.
- Accumulates group propagate/generate alongside the sum for carry-lookahead checking.
- Sits between the top-level pin wrapper (operands from dedicated/bidirectional inputs) and the result outputs.

---
 rtl/serial_add_seq_pkg.sv | 21 ++
 rtl/serial_fa_cell.sv | 16 +
 rtl/serial_add_seq.sv | 153 +++++++++++++++
 tb/tb_serial_add_seq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
// The state encoding is fixed at 00/01/10; 11 is illegal and recovers to idle.
package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned WidthMin = 2;
    localparam int unsigned WidthMax = 16;

    // Bit counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        int unsigned c;
        c = int'($clog2(w));
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single full-adder cell exposing propagate, generate and sum.
// The sequencer reuses this cell for every bit position.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_prop,
    output logic o_gen,
    output logic o_sout
);

    assign o_prop = i_a ^ i_b;
    assign o_gen  = i_a & i_b;
    assign o_sout = o_prop ^ i_cin;

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over WIDTH cycles,
// also accumulating group propagate/generate for carry-lookahead cross-checking.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_grp_prop,
    output logic             o_grp_gen
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    generate
        if (WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_width
            $error("serial_add_seq: WIDTH out of range");
        end
    endgenerate

    state_e           r_state;
    state_e           w_state_next;
    logic [CntW-1:0]  r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_pacc;
    logic             r_gacc;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_grp_prop;
    logic             r_grp_gen;

    logic             w_prop;
    logic             w_gen;
    logic             w_sout;
    logic             w_last;
    logic             w_carry_next;
    logic             w_pacc_next;
    logic             w_gacc_next;
    logic [WIDTH-1:0] w_sum_next;

    serial_fa_cell u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry),
        .o_prop (w_prop),
        .o_gen  (w_gen),
        .o_sout (w_sout)
    );

    assign w_last       = (r_cnt == CntW'(WIDTH - 1));
    assign w_carry_next = w_gen | (w_prop & r_carry);
    assign w_pacc_next  = r_pacc & w_prop;
    assign w_gacc_next  = w_gen | (w_prop & r_gacc);
    // Sum bits enter at the MSB so bit 0 lands at index 0 after WIDTH shifts.
    assign w_sum_next   = {w_sout, r_sum_sh[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_done       = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum_sh   <= '0;
            r_pacc     <= 1'b0;
            r_gacc     <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_grp_prop <= 1'b0;
            r_grp_gen  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a_sh  <= i_a;
                        r_b_sh  <= i_b;
                        r_carry <= i_cin;
                        r_cnt   <= '0;
                        r_pacc  <= 1'b1;
                        r_gacc  <= 1'b0;
                    end
                end
                StRun: begin
                    r_carry  <= w_carry_next;
                    r_pacc   <= w_pacc_next;
                    r_gacc   <= w_gacc_next;
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    if (w_last) begin
                        r_cnt      <= '0;
                        r_sum      <= w_sum_next;
                        r_cout     <= w_carry_next;
                        r_grp_prop <= w_pacc_next;
                        r_grp_gen  <= w_gacc_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_grp_prop = r_grp_prop;
    assign o_grp_gen  = r_grp_gen;

endmodule

// File: tb/tb_serial_add_seq.sv
// Scoreboard bench for serial_add_seq: stimulus pushes reference results, a negedge
// monitor pops and compares them whenever done is presented.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         grp_prop;
    logic         grp_gen;

    serial_add_seq #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .i_cin      (cin),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_cout     (cout),
        .o_grp_prop (grp_prop),
        .o_grp_gen  (grp_gen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         gp;
        logic         gg;
        logic         cin;
        int           done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   dones_seen = 0;
    int   ops_pushed = 0;
    int   busy_run   = 0;
    logic rst_at_edge = 1'b0;
    logic [W+2:0] prev_out = '0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst_n;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference: plain integer addition; group generate is the carry-out of a+b alone.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                   input logic tc);
        exp_t       e;
        logic [W:0] t;
        logic [W:0] g;
        t = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
        g = {1'b0, ta} + {1'b0, tb_v};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.gp   = &(ta ^ tb_v);
        e.gg   = g[W];
        e.cin  = tc;
        e.done_cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_at_edge) begin
            if (busy) busy_run++;
            if (done) begin
                dones_seen++;
                if (sb_q.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("grp_prop", 32'(grp_prop), 32'(e.gp));
                    check("grp_gen", 32'(grp_gen), 32'(e.gg));
                    check("cout_invariant", 32'(cout), 32'(grp_gen | (grp_prop & e.cin)));
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("busy_cycles", 32'(busy_run), 32'(W));
                end
                busy_run = 0;
            end else begin
                check("outputs_stable", 32'({sum, cout, grp_prop, grp_gen}), 32'(prev_out));
            end
        end else begin
            busy_run = 0;
        end
        prev_out = {sum, cout, grp_prop, grp_gen};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 4 * W) begin
            step();
            n++;
        end
        if (busy || done) check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         output int acc);
        exp_t e;
        wait_idle();
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        acc   = cyc + 1;
        e = model(ta, tb_v, tc);
        e.done_cyc = acc + W;
        sb_q.push_back(e);
        ops_pushed++;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 4 * W) begin
            step();
            n++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        step();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_gprop"}, 32'(grp_prop), 32'd0);
        check({tag, "_ggen"}, 32'(grp_gen), 32'd0);
    endtask

    initial begin
        int acc;
        int prev_acc;
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // Directed vectors.
        issue(8'h5A, 8'h3C, 1'b0, acc);
        step();
        start = 1'b0;
        drain();
        issue(8'hFF, 8'h01, 1'b0, acc);
        step();
        start = 1'b0;
        drain();
        issue(8'hFF, 8'h00, 1'b1, acc);
        step();
        start = 1'b0;
        drain();

        // start re-pulsed and operands changed while running must be ignored.
        d0 = dones_seen;
        issue(8'h12, 8'h34, 1'b1, acc);
        step();
        start = 1'b0;
        repeat (2) step();
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'b0;
        repeat (W - 3) step();
        start = 1'b0;
        drain();
        repeat (W + 4) step();
        check("midrun_done_count", 32'(dones_seen - d0), 32'd1);

        // Reset asserted on the edge that processes bit 4.
        d0 = dones_seen;
        issue(8'hA5, 8'h0F, 1'b0, acc);
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        void'(sb_q.pop_back());
        ops_pushed--;
        @(negedge clk);
        check_zero_outputs("abort");
        repeat (W + 4) step();
        check("abort_no_done", 32'(dones_seen - d0), 32'd0);

        // start held high, random operands: one result every W+2 cycles.
        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), acc);
            if (i > 0) check("throughput", 32'(acc - prev_acc), 32'(W + 2));
            prev_acc = acc;
            step();
        end
        start = 1'b0;
        drain();
        repeat (4) step();

        check("queue_empty", 32'(sb_q.size()), 32'd0);
        check("done_total", 32'(dones_seen), 32'(ops_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
